// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI command stream block.
package spi_pkg;

    localparam int unsigned CMD_BITS = 8;

    localparam logic [3:0] OP_WRITE = 4'h9;
    localparam logic [3:0] OP_BCAST = 4'hA;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_DATA = 3'd2,
        ST_SKIP = 3'd3,
        ST_COPY = 3'd4
    } state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Synchronizes the asynchronous SPI pins into clk and detects sclk rising edges.
module spi_input_sync (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic mosi,
    input  logic cs_n,
    output logic cs_n_s,
    output logic mosi_s,
    output logic sclk_rise
);

    logic [2:0] sclk_q;
    logic [1:0] mosi_q;
    logic [1:0] cs_q;

    // Two-flop synchronizers; sclk gets a third flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= '0;
            mosi_q <= '0;
            cs_q   <= 2'b11;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            mosi_q <= {mosi_q[0], mosi};
            cs_q   <= {cs_q[0], cs_n};
        end
    end

    assign cs_n_s    = cs_q[1];
    assign mosi_s    = mosi_q[1];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];

endmodule

// File: rtl/spi_cmd_stream.sv
// Oversampled SPI slave: decodes a command byte, collects a data word and
// delivers it to one channel or all channels with a single-cycle strobe.
module spi_cmd_stream
    import spi_pkg::*;
#(
    parameter int unsigned DATA_BITS = 16,
    parameter int unsigned NUM_CH    = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 mosi,
    input  logic                 cs_n,
    output logic [DATA_BITS-1:0] out_data,
    output logic [NUM_CH-1:0]    out_ch_mask,
    output logic                 out_valid,
    output logic                 err_cmd,
    output logic                 err_abort,
    output logic                 busy
);

    localparam int unsigned DCW = $clog2(DATA_BITS + 1);
    localparam int unsigned IW  = $clog2(DATA_BITS);

    logic cs_n_s, mosi_s, sclk_rise;

    spi_input_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .cs_n_s    (cs_n_s),
        .mosi_s    (mosi_s),
        .sclk_rise (sclk_rise)
    );

    state_t               state, state_nx;
    logic [3:0]           cmd_cnt, cmd_cnt_nx;
    logic [DCW-1:0]       dat_cnt, dat_cnt_nx;
    logic [CMD_BITS-1:0]  cmd_sh, cmd_sh_nx, cmd_new;
    logic [DATA_BITS-1:0] dat_sh, dat_sh_nx, dat_new;
    logic [NUM_CH-1:0]    ch_mask, ch_mask_nx, cmd_mask;
    logic [DATA_BITS-1:0] out_data_nx;
    logic [NUM_CH-1:0]    out_ch_mask_nx;
    logic                 out_valid_nx, err_cmd_nx, err_abort_nx, busy_nx;
    logic                 cmd_legal;
    logic [2:0]           cmd_idx;
    logic [IW-1:0]        dat_idx;
    logic [1:0]           warm;
    logic                 armed;

    // Frame start is armed only once a real cs_n high has crossed the synchronizer after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm  <= '0;
            armed <= 1'b0;
        end else begin
            warm <= {warm[0], 1'b1};
            if (warm[1] && cs_n_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Place the incoming bit at its final position for the configured bit order.
    always_comb begin
        cmd_idx = LSB_FIRST ? cmd_cnt[2:0] : 3'(CMD_BITS - 1 - 32'(cmd_cnt));
        dat_idx = LSB_FIRST ? IW'(dat_cnt) : IW'(DATA_BITS - 1 - 32'(dat_cnt));
        cmd_new = cmd_sh;
        cmd_new[cmd_idx] = mosi_s;
        dat_new = dat_sh;
        dat_new[dat_idx] = mosi_s;
    end

    // Command decode on the completed byte.
    always_comb begin
        cmd_legal = 1'b0;
        cmd_mask  = '0;
        if (cmd_new[7:4] == OP_WRITE && 32'(cmd_new[3:0]) < NUM_CH) begin
            cmd_legal = 1'b1;
            cmd_mask  = NUM_CH'(1) << cmd_new[3:0];
        end else if (cmd_new[7:4] == OP_BCAST) begin
            cmd_legal = 1'b1;
            cmd_mask  = '1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cmd_cnt     <= '0;
            dat_cnt     <= '0;
            cmd_sh      <= '0;
            dat_sh      <= '0;
            ch_mask     <= '0;
            out_data    <= '0;
            out_ch_mask <= '0;
            out_valid   <= 1'b0;
            err_cmd     <= 1'b0;
            err_abort   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            cmd_cnt     <= cmd_cnt_nx;
            dat_cnt     <= dat_cnt_nx;
            cmd_sh      <= cmd_sh_nx;
            dat_sh      <= dat_sh_nx;
            ch_mask     <= ch_mask_nx;
            out_data    <= out_data_nx;
            out_ch_mask <= out_ch_mask_nx;
            out_valid   <= out_valid_nx;
            err_cmd     <= err_cmd_nx;
            err_abort   <= err_abort_nx;
            busy        <= busy_nx;
        end
    end

    // Next-state and next-output logic; cs_n high overrides everything.
    always_comb begin
        state_nx       = state;
        cmd_cnt_nx     = cmd_cnt;
        dat_cnt_nx     = dat_cnt;
        cmd_sh_nx      = cmd_sh;
        dat_sh_nx      = dat_sh;
        ch_mask_nx     = ch_mask;
        out_data_nx    = out_data;
        out_ch_mask_nx = out_ch_mask;
        out_valid_nx   = 1'b0;
        err_cmd_nx     = 1'b0;
        err_abort_nx   = 1'b0;

        if (cs_n_s) begin
            state_nx     = ST_IDLE;
            cmd_cnt_nx   = '0;
            dat_cnt_nx   = '0;
            cmd_sh_nx    = '0;
            dat_sh_nx    = '0;
            err_abort_nx = (state == ST_DATA || state == ST_SKIP) && (dat_cnt != '0);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (armed) begin
                        state_nx   = ST_CMD;
                        cmd_cnt_nx = '0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        cmd_sh_nx = cmd_new;
                        if (cmd_cnt == 4'(CMD_BITS - 1)) begin
                            dat_cnt_nx = '0;
                            if (cmd_legal) begin
                                state_nx   = ST_DATA;
                                ch_mask_nx = cmd_mask;
                            end else begin
                                state_nx   = ST_SKIP;
                                err_cmd_nx = 1'b1;
                            end
                        end else begin
                            cmd_cnt_nx = cmd_cnt + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_rise) begin
                        dat_sh_nx = dat_new;
                        if (dat_cnt == DCW'(DATA_BITS - 1)) begin
                            state_nx       = ST_COPY;
                            out_data_nx    = dat_new;
                            out_ch_mask_nx = ch_mask;
                            out_valid_nx   = 1'b1;
                        end else begin
                            dat_cnt_nx = dat_cnt + DCW'(1);
                        end
                    end
                end
                ST_SKIP: begin
                    if (sclk_rise) begin
                        if (dat_cnt == DCW'(DATA_BITS - 1)) begin
                            state_nx   = ST_CMD;
                            cmd_cnt_nx = '0;
                        end else begin
                            dat_cnt_nx = dat_cnt + DCW'(1);
                        end
                    end
                end
                ST_COPY: begin
                    state_nx   = ST_CMD;
                    cmd_cnt_nx = '0;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end

        busy_nx = (state_nx == ST_CMD) || (state_nx == ST_DATA) || (state_nx == ST_COPY);
    end

endmodule

// File: tb/tb_spi_cmd_stream.sv
// Bench for spi_cmd_stream: two instances (16b/4ch/LSB-first and 8b/1ch/MSB-first)
// share sclk/mosi and are selected by their own chip selects.
module tb_spi_cmd_stream;

    localparam int unsigned DB0 = 16;
    localparam int unsigned NC0 = 4;
    localparam int unsigned DB1 = 8;
    localparam int unsigned NC1 = 1;

    typedef struct packed {
        logic [63:0] d;
        logic [15:0] m;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic sclk;
    logic mosi;
    logic cs_n0;
    logic cs_n1;

    logic [DB0-1:0] od0;
    logic [NC0-1:0] om0;
    logic           v0, ec0, ea0, b0;
    logic [DB1-1:0] od1;
    logic [NC1-1:0] om1;
    logic           v1, ec1, ea1, b1;

    int checks = 0;
    int errors = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        e0, e1;
    logic [63:0] md[2];
    logic [15:0] mm[2];
    int          exp_ec[2];
    int          exp_ea[2];
    int          seen_ec[2];
    int          seen_ea[2];

    spi_cmd_stream #(.DATA_BITS(DB0), .NUM_CH(NC0), .LSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n0),
        .out_data(od0), .out_ch_mask(om0), .out_valid(v0),
        .err_cmd(ec0), .err_abort(ea0), .busy(b0)
    );

    spi_cmd_stream #(.DATA_BITS(DB1), .NUM_CH(NC1), .LSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n1),
        .out_data(od1), .out_ch_mask(om1), .out_valid(v1),
        .err_cmd(ec1), .err_abort(ea1), .busy(b1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic dut_valid(input int inst);
        return (inst == 0) ? v0 : v1;
    endfunction

    function automatic logic dut_busy(input int inst);
        return (inst == 0) ? b0 : b1;
    endfunction

    // Per-cycle compare against the model: words pop on each strobe, outputs hold otherwise.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                q0.delete();
                q1.delete();
                md[0] = '0; mm[0] = '0;
                md[1] = '0; mm[1] = '0;
            end else begin
                if (v0) begin
                    if (q0.size() == 0) chk("unexpected_valid0", 64'(v0), 64'd0);
                    else begin
                        e0 = q0.pop_front();
                        md[0] = e0.d; mm[0] = e0.m;
                    end
                end
                if (v1) begin
                    if (q1.size() == 0) chk("unexpected_valid1", 64'(v1), 64'd0);
                    else begin
                        e1 = q1.pop_front();
                        md[1] = e1.d; mm[1] = e1.m;
                    end
                end
                chk("out_data0", 64'(od0), md[0]);
                chk("out_ch_mask0", 64'(om0), 64'(mm[0]));
                chk("out_data1", 64'(od1), md[1]);
                chk("out_ch_mask1", 64'(om1), 64'(mm[1]));
                if (ec0) seen_ec[0]++;
                if (ea0) seen_ea[0]++;
                if (ec1) seen_ec[1]++;
                if (ea1) seen_ea[1]++;
            end
        end
    end

    task automatic send_bit(input int inst, input logic b, input bit chk_lat);
        @(negedge clk);
        mosi = b;
        repeat (3) @(negedge clk);
        sclk = 1'b1;
        if (chk_lat) begin
            repeat (2) @(posedge clk);
            #1 chk("valid_early", 64'(dut_valid(inst)), 64'd0);
            @(posedge clk);
            #1 chk("valid_latency", 64'(dut_valid(inst)), 64'd1);
            @(negedge clk);
        end else begin
            repeat (3) @(negedge clk);
        end
        @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_word(input int inst, input logic [63:0] w, input int n,
                             input bit lsb, input bit chk_lat);
        for (int i = 0; i < n; i++) begin
            int k;
            k = lsb ? i : (n - 1 - i);
            send_bit(inst, w[6'(k)], chk_lat && (i == n - 1));
        end
    endtask

    task automatic begin_frame(input int inst);
        @(negedge clk);
        if (inst == 0) cs_n0 = 1'b0; else cs_n1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_frame_start", 64'(dut_busy(inst)), 64'd1);
    endtask

    task automatic end_frame(input int inst);
        @(negedge clk);
        if (inst == 0) cs_n0 = 1'b1; else cs_n1 = 1'b1;
        repeat (6) @(negedge clk);
        chk("busy_idle", 64'(dut_busy(inst)), 64'd0);
    endtask

    // Model a command/data pair from the decode rules, then drive it.
    task automatic cmd_data(input int inst, input logic [7:0] cmd, input logic [63:0] data);
        int   nb, nc, ch;
        bit   lsb, legal;
        exp_t e;
        nb  = (inst == 0) ? int'(DB0) : int'(DB1);
        nc  = (inst == 0) ? int'(NC0) : int'(NC1);
        lsb = (inst == 0);
        ch  = int'(cmd[3:0]);
        legal = 1'b0;
        e.d = data;
        e.m = '0;
        if (cmd[7:4] == 4'h9 && ch < nc) begin
            legal = 1'b1;
            e.m = 16'(1 << ch);
        end else if (cmd[7:4] == 4'hA) begin
            legal = 1'b1;
            e.m = 16'((1 << nc) - 1);
        end
        if (legal) begin
            if (inst == 0) q0.push_back(e); else q1.push_back(e);
        end else begin
            exp_ec[inst]++;
        end
        send_word(inst, 64'(cmd), 8, lsb, 1'b0);
        chk("busy_after_cmd", 64'(dut_busy(inst)), legal ? 64'd1 : 64'd0);
        send_word(inst, data, nb, lsb, legal);
    endtask

    task automatic chk_counts(input int inst);
        chk("err_cmd_count", 64'(seen_ec[inst]), 64'(exp_ec[inst]));
        chk("err_abort_count", 64'(seen_ea[inst]), 64'(exp_ea[inst]));
        chk("pending_words", 64'((inst == 0) ? q0.size() : q1.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_n0 = 1'b1; cs_n1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            md[i] = '0; mm[i] = '0;
            exp_ec[i] = 0; exp_ea[i] = 0; seen_ec[i] = 0; seen_ea[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_out_data0", 64'(od0), 64'd0);
        chk("rst_mask0", 64'(om0), 64'd0);
        chk("rst_flags0", 64'({v0, ec0, ea0, b0}), 64'd0);
        chk("rst_out_data1", 64'(od1), 64'd0);
        chk("rst_flags1", 64'({om1, v1, ec1, ea1, b1}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // sclk activity with both chip selects high
        send_word(0, 64'hFF, 8, 1'b1, 1'b0);
        chk_counts(0);
        chk_counts(1);

        // single WRITE to channel 2
        begin_frame(0);
        cmd_data(0, 8'h92, 64'hA5C3);
        end_frame(0);
        chk("t_write_data", 64'(od0), 64'hA5C3);
        chk("t_write_mask", 64'(om0), 64'b0100);
        chk_counts(0);

        // back-to-back WRITE then BROADCAST in one frame
        begin_frame(0);
        cmd_data(0, 8'h90, 64'h1234);
        chk("t_b2b_mask_a", 64'(om0), 64'b0001);
        cmd_data(0, 8'hA0, 64'hBEEF);
        end_frame(0);
        chk("t_b2b_data", 64'(od0), 64'hBEEF);
        chk("t_b2b_mask_b", 64'(om0), 64'b1111);
        chk_counts(0);

        // illegal channel skipped, following command still decoded
        begin_frame(0);
        cmd_data(0, 8'h95, 64'h5555);
        cmd_data(0, 8'h93, 64'h0F0F);
        end_frame(0);
        chk("t_ill_data", 64'(od0), 64'h0F0F);
        chk("t_ill_mask", 64'(om0), 64'b1000);
        chk("t_ill_errs", 64'(seen_ec[0]), 64'd1);
        chk_counts(0);

        // abort after 9 data bits
        begin_frame(0);
        send_word(0, 64'h91, 8, 1'b1, 1'b0);
        send_word(0, 64'h1FF, 9, 1'b1, 1'b0);
        exp_ea[0]++;
        end_frame(0);
        chk("t_abort_hold", 64'(od0), 64'h0F0F);
        chk("t_abort_errs", 64'(seen_ea[0]), 64'd1);
        chk_counts(0);
        begin_frame(0);
        cmd_data(0, 8'h91, 64'h6789);
        end_frame(0);
        chk("t_post_abort_mask", 64'(om0), 64'b0010);
        chk_counts(0);

        // reset mid-data, rest of frame ignored, then fresh frame
        begin_frame(0);
        send_word(0, 64'h93, 8, 1'b1, 1'b0);
        send_word(0, 64'h15, 5, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t_rst0_data", 64'(od0), 64'd0);
        chk("t_rst0_flags", 64'({om0, v0, ec0, ea0, b0}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_word(0, 64'hFFFF, 11, 1'b1, 1'b0);
        chk("t_rst0_busy", 64'(b0), 64'd0);
        end_frame(0);
        chk_counts(0);
        begin_frame(0);
        cmd_data(0, 8'hA7, 64'hC0DE);
        end_frame(0);
        chk("t_rst0_fresh", 64'(od0), 64'hC0DE);
        chk_counts(0);

        // 8-bit, single channel, MSB-first instance
        begin_frame(1);
        cmd_data(1, 8'h90, 64'h5A);
        cmd_data(1, 8'h91, 64'h33);
        cmd_data(1, 8'hA5, 64'h81);
        end_frame(1);
        chk("t1_data", 64'(od1), 64'h81);
        chk("t1_mask", 64'(om1), 64'd1);
        chk_counts(1);
        begin_frame(1);
        send_word(1, 64'h90, 8, 1'b0, 1'b0);
        send_word(1, 64'h1F, 5, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t1_rst_flags", 64'({od1, om1, v1, ec1, ea1, b1}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_word(1, 64'h7, 3, 1'b0, 1'b0);
        end_frame(1);
        chk_counts(1);
        begin_frame(1);
        cmd_data(1, 8'h90, 64'hC3);
        end_frame(1);
        chk("t1_fresh", 64'(od1), 64'hC3);
        chk_counts(1);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_cmd_stream.md
# spi_cmd_stream

Parametrised, multi-channel successor to the team's SPI command controller. It runs entirely on one system clock: the SPI pins are oversampled, an 8-bit command is decoded, and a DATA_BITS word is streamed into a parallel register. Each completed word is delivered to one channel, or broadcast to all channels, with a single-cycle valid strobe. Multiple command/data pairs are allowed per chip-select frame. Aborted frames and bad commands are flagged.

## Interface
- DATA_BITS, 16, payload width per command (2..64)
- NUM_CH, 4, number of target channels (1..16)
- LSB_FIRST, 1, bit order of command and data on mosi (1 = LSB first, 0 = MSB first)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sclk  in  1  SPI clock pin, asynchronous to clk, mode 0
- mosi  in  1  SPI data pin, asynchronous
- cs_n  in  1  SPI chip select, active low, asynchronous
- out_data  out  DATA_BITS  last completed word, held until the next out_valid
- out_ch_mask  out  NUM_CH  one-hot channel mask, or all ones for broadcast; qualified by out_valid
- out_valid  out  1  one-clk pulse per completed word
- err_cmd  out  1  one-clk pulse on an illegal command byte
- err_abort  out  1  one-clk pulse when cs_n rises mid-data
- busy  out  1  high in CMD, DATA or COPY

## Operation
- Input sync: sclk, mosi and cs_n each pass through a 2-flop synchronizer. A third flop on sclk gives rising-edge detection (rise = s2 & ~s3).
- A bit is sampled on the detected rising edge of sclk while synced cs_n = 0.
- Command byte cmd[7:0], assembled in the order set by LSB_FIRST:
  - cmd[7:4] = 4'h9: WRITE to channel cmd[3:0]
  - cmd[7:4] = 4'hA: BROADCAST (mask all ones); cmd[3:0] is ignored
  - Any other opcode, or WRITE with cmd[3:0] >= NUM_CH, is illegal.
- FSM states: IDLE, CMD, DATA, SKIP, COPY.
  - IDLE -> CMD when synced cs_n falls. cmd bit count clears to 0.
  - CMD -> DATA on the 8th bit if the command is legal. The data bit count clears and the mask is latched.
  - CMD -> SKIP on the 8th bit if the command is illegal. err_cmd pulses in the following clk.
  - SKIP: consumes DATA_BITS bits without updating any output, then goes to CMD.
  - DATA -> COPY on the DATA_BITS-th bit. The shift register holds the complete word.
  - COPY -> CMD after exactly one clk. out_data and out_ch_mask load and out_valid = 1 during that clk.
  - Any state -> IDLE when synced cs_n = 1. Counters and the shift register clear. err_abort pulses if the state was DATA or SKIP with count > 0. A partial CMD byte is dropped silently.
- Widths: bit counters are $clog2(DATA_BITS+1) and 4 bits and must never wrap inside a field. A counter reaching its terminal count forces the transition on that same edge.
- out_data and out_ch_mask change only in COPY. Abort or reset-free idle never disturbs them.

## Timing
- Reset (async assert, release synchronous to clk): state = IDLE. out_data = 0, out_ch_mask = 0, out_valid = err_cmd = err_abort = busy = 0. cs_n sync flops reset to 1; sclk and mosi sync flops reset to 0.
- Reset asserted mid-frame: everything returns to reset values immediately, with no out_valid or err pulse. Bit collection resumes only after cs_n rises and falls again.
- Pin-to-sample latency: 3 clk cycles from a sclk rising edge.
- Clocking requirements: sclk high and low phases must each be >= 3 clk periods. mosi must be stable from the sclk rising edge until 3 clk periods after it.
- out_valid asserts 1 clk after the clk in which the last data bit is sampled.
- The next command's first bit may be sampled in the clk right after COPY. Back-to-back words need no gap.
- If cs_n rises in the same clk as the final data bit is sampled: cs_n takes priority, the word is discarded and err_abort pulses.

## Structure
- Package spi_pkg holds:
  - opcode constants OP_WRITE = 4'h9 and OP_BCAST = 4'hA
  - the state encoding (3 bits)
  - the CMD_BITS = 8 constant
- Sub-module spi_input_sync contains the synchronizers and the edge detector. Outputs: cs_n_s, mosi_s, sclk_rise.
- Top level contains the FSM, counters, shift register and output registers.

## Test plan
- Reset and idle: reset with cs_n=1 -> all outputs 0, busy=0; toggling sclk alone produces no pulses.
- WRITE ch2, data 0xA5C3: LSB-first frame 0x92 then 0xA5C3 -> exactly one out_valid; out_data=16'hA5C3, out_ch_mask=4'b0100, valid 1 clk after the last bit.
- Back-to-back in one frame: 0x90 + 0x1234, then 0xA0 + 0xBEEF -> two out_valid pulses; masks 4'b0001, then 4'b1111.
- Illegal commands: 0x95 (channel 5 with NUM_CH=4) + 16 bits, then 0x93 + 0x0F0F -> err_cmd once; the only out_valid carries 0x0F0F with mask 4'b1000.
- Abort: 0x91 + 9 data bits, then cs_n high -> err_abort once, no out_valid, out_data keeps its prior value. The next full frame works normally.
- Async reset asserted after 5 data bits -> immediate reset values, no pulses. A fresh frame afterwards is decoded correctly. Repeat with DATA_BITS=8, NUM_CH=1, LSB_FIRST=0.
